// File: rtl/pcileech_rx_packer_pkg.sv
// rtl/pcileech_rx_packer_pkg.sv - shared types and helpers for the FT245 RX byte-to-dword packer
//
// Purpose: types shared by the packer top and its 2-entry output buffer.
//   PACK_PAD_BYTE  filler used for the missing bytes of a flushed dword
//   pk_dword_t     32-bit little-endian dword
//   pk_entry_t     buffered dword plus its "flushed, not filled" flag
//   pk_state_t     packer FSM states
//   pk_pad()       pads byte positions idx..3 of a partial dword
package pcileech_rx_packer_pkg;

  localparam logic [7:0] PACK_PAD_BYTE = 8'hFF;

  typedef logic [31:0] pk_dword_t;

  typedef struct packed {
    pk_dword_t data;
    logic      partial;
  } pk_entry_t;

  typedef enum logic [1:0] {
    PK_IDLE       = 2'd0,
    PK_FILL       = 2'd1,
    PK_FLUSH_PEND = 2'd2
  } pk_state_t;

  // Bytes below idx were collected; everything from idx upwards is padding.
  function automatic pk_dword_t pk_pad(input logic [23:0] coll, input logic [1:0] idx);
    pk_dword_t w;
    w = {PACK_PAD_BYTE, coll};
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(idx)) w[8*k +: 8] = PACK_PAD_BYTE;
    end
    return w;
  endfunction

endpackage

// File: rtl/pcileech_rx_packer_skid2.sv
// rtl/pcileech_rx_packer_skid2.sv - 2-entry in-order buffer for finished packer dwords
//
// Purpose: holds up to two pk_entry_t words between the packer and the com RX FIFO.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_entry (ignored while full; the packer never pushes when full)
//   push_entry   entry to store
//   pop_ready    sink ready; pops the head when out_valid is also high
//   head         oldest entry
//   out_valid    buffer not empty
//   cnt          number of stored entries (0..2)
module pcileech_rx_packer_skid2
  import pcileech_rx_packer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pk_entry_t  push_entry,
  input  logic       pop_ready,
  output pk_entry_t  head,
  output logic       out_valid,
  output logic [1:0] cnt
);

  pk_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      do_push;
  logic      do_pop;

  assign out_valid = (cnt != 2'd0);
  assign do_pop    = out_valid & pop_ready;
  // Fullness is judged on the registered count only, so a same-cycle pop
  // never lets a third word in; this keeps in_ready free of out_ready.
  assign do_push   = push & (cnt != 2'd2);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pcileech_ft245_rx_packer.sv
// rtl/pcileech_ft245_rx_packer.sv - packs the FT245 RX byte stream into little-endian dwords
//
// Purpose: collects bytes from the FT245 pad controller into 32-bit dwords
//   (byte k in bits [8k+7:8k]) and hands them to the com RX FIFO through a
//   2-entry buffer.
// Optional feature: PCILEECH_RX_PACKER_FLUSH_EN enables the idle-timeout flush
//   of a partial dword (missing bytes 8'hFF, out_partial=1).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_data/in_valid/in_ready  byte stream in
//   out_data/out_partial/
//   out_valid/out_ready        dword stream out
//   stat_words_out             dwords delivered, wraps
//   stat_flush_cnt             flushes performed, saturates
module pcileech_ft245_rx_packer
  import pcileech_rx_packer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STAT_FLUSH_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [31:0]             out_data,
  output logic                    out_partial,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             stat_words_out,
  output logic [STAT_FLUSH_W-1:0] stat_flush_cnt
);

  logic [23:0] coll;
  logic [1:0]  idx;
  logic [1:0]  cnt;
  pk_state_t   state;
  pk_state_t   state_nxt;
  logic        accept;
  logic        push;
  logic        flush_push;
  logic        timeout;
  pk_entry_t   push_entry;
  pk_entry_t   head;

  // Registers only: the 4th byte needs a free buffer slot, and nothing enters
  // while a flush word is waiting for room.
  assign in_ready = rst_n & (state != PK_FLUSH_PEND) & ((idx != 2'd3) | (cnt < 2'd2));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    flush_push = 1'b0;
    push_entry = '{data: {in_data, coll}, partial: 1'b0};
    case (state)
      PK_IDLE: begin
        if (accept) state_nxt = PK_FILL;
      end
      PK_FILL: begin
        if (accept && idx == 2'd3) begin
          push      = 1'b1;
          state_nxt = PK_IDLE;
        end
`ifdef PCILEECH_RX_PACKER_FLUSH_EN
        // A byte arriving in the timeout cycle wins over the flush.
        else if (timeout && !accept) begin
          if (cnt < 2'd2) flush_push = 1'b1;
          else            state_nxt  = PK_FLUSH_PEND;
        end
`endif
      end
`ifdef PCILEECH_RX_PACKER_FLUSH_EN
      PK_FLUSH_PEND: begin
        if (cnt < 2'd2) flush_push = 1'b1;
      end
`endif
      default: state_nxt = PK_IDLE;
    endcase
    if (flush_push) begin
      push       = 1'b1;
      push_entry = '{data: pk_pad(coll, idx), partial: 1'b1};
      state_nxt  = PK_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PK_IDLE;
      coll  <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (flush_push) begin
        idx <= 2'd0;
      end else if (accept) begin
        // The 4th byte goes straight into the pushed word, not the collector.
        case (idx)
          2'd0:    coll[7:0]   <= in_data;
          2'd1:    coll[15:8]  <= in_data;
          2'd2:    coll[23:16] <= in_data;
          default: coll        <= coll;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

  pcileech_rx_packer_skid2 u_skid2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop_ready  (out_ready),
    .head       (head),
    .out_valid  (out_valid),
    .cnt        (cnt)
  );

  assign out_data = head.data;

  always_ff @(posedge clk) begin
    if (!rst_n)                     stat_words_out <= 32'd0;
    else if (out_valid & out_ready) stat_words_out <= stat_words_out + 32'd1;
  end

`ifdef PCILEECH_RX_PACKER_FLUSH_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] idle_cnt;

  // Holds at the timeout value while a flush waits in FLUSH_PEND.
  always_ff @(posedge clk) begin
    if (!rst_n || accept || idx == 2'd0)            idle_cnt <= '0;
    else if (idle_cnt != TIMEOUT_CYCLES[IW-1:0])    idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (idx != 2'd0) && (idle_cnt == TIMEOUT_CYCLES[IW-1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n)                               stat_flush_cnt <= '0;
    else if (flush_push && ~&stat_flush_cnt)  stat_flush_cnt <= stat_flush_cnt + 1'b1;
  end

  assign out_partial = head.partial;
`else
  logic unused_cfg;

  assign timeout        = 1'b0;
  assign out_partial    = 1'b0;
  assign stat_flush_cnt = '0;
  assign unused_cfg     = head.partial ^ TIMEOUT_CYCLES[0] ^ timeout;
`endif

endmodule

// File: tb/tb_pcileech_ft245_rx_packer.sv
// tb/tb_pcileech_ft245_rx_packer.sv - directed and randomized bench for pcileech_ft245_rx_packer
module tb_pcileech_ft245_rx_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_partial;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] stat_words_out;
  logic [15:0] stat_flush_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_q [$];
  logic        got_p [$];

  pcileech_ft245_rx_packer #(
    .TIMEOUT_CYCLES (16),
    .STAT_FLUSH_W   (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_partial    (out_partial),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .stat_words_out (stat_words_out),
    .stat_flush_cnt (stat_flush_cnt)
  );

  always #5 clk = ~clk;

  // Record every handshaken dword; inputs only change #1 after posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_p.push_back(out_partial);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
    got_q.delete();
    got_p.delete();
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    check_eq("word_count", got_q.size(), n);
  endtask

  logic [7:0]  rbytes [400];
  logic [31:0] exp_w;
  bit          seen;
  bit          rnd_done;
  int          k;

  initial begin
    // Reset state
    tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_partial", out_partial, 0);
    check_eq("rst_words", stat_words_out, 0);
    check_eq("rst_flush", stat_flush_cnt, 0);
    do_reset(1);

    // 1: basic pack, one-cycle latency
    out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_data", out_data, 32'h44332211);
    check_eq("t1_partial", out_partial, 0);
    tick();
    check_eq("t1_words", stat_words_out, 1);
    check_eq("t1_empty", out_valid, 0);

    // 2: back-pressure with a full buffer
    do_reset(2);
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(8'(i));
    in_valid = 1'b1;
    in_data  = 8'h0B;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t2_in_ready_low", in_ready, 0);
    check_eq("t2_head", out_data, 32'h03020100);
    out_ready = 1'b1;
    send(8'h0B);
    wait_words(3, 50);
    if (got_q.size() >= 3) begin
      check_eq("t2_w0", got_q[0], 32'h03020100);
      check_eq("t2_w1", got_q[1], 32'h07060504);
      check_eq("t2_w2", got_q[2], 32'h0B0A0908);
    end
    tick();
    check_eq("t2_words", stat_words_out, 3);

    // 5: reset in the middle of a dword discards it and clears counters
    send(8'h01); send(8'h02); send(8'h03);
    rst_n = 1'b0;
    tick();
    check_eq("t5_rst_words", stat_words_out, 0);
    check_eq("t5_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    got_q.delete();
    got_p.delete();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    wait_words(1, 20);
    for (int i = 0; i < 10; i++) tick();
    check_eq("t5_count", got_q.size(), 1);
    if (got_q.size() >= 1) check_eq("t5_w0", got_q[0], 32'h04030201);
    check_eq("t5_words", stat_words_out, 1);

    // 3: idle timeout flush of a partial dword
    do_reset(2);
    out_ready = 1'b1;
    send(8'hAA); send(8'hBB);
`ifdef PCILEECH_RX_PACKER_FLUSH_EN
    k = 0;
    while (k < 100 && !out_valid) begin
      tick();
      k++;
    end
    check_eq("t3_latency", k, 17);
    check_eq("t3_data", out_data, 32'hFFFFBBAA);
    check_eq("t3_partial", out_partial, 1);
    check_eq("t3_flush_cnt", stat_flush_cnt, 1);
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check_eq("t3_no_flush", seen, 0);
    check_eq("t3_flush_cnt", stat_flush_cnt, 0);
    check_eq("t3_in_ready", in_ready, 1);
`endif

`ifdef PCILEECH_RX_PACKER_FLUSH_EN
    // 4: timeout with a full buffer waits in FLUSH_PEND
    do_reset(2);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i));
    send(8'hAA);
    k = 0;
    while (k < 100 && in_ready) begin
      tick();
      k++;
    end
    check_eq("t4_pend_latency", k, 17);
    check_eq("t4_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check_eq("t4_in_ready_back", in_ready, 1);
    out_ready = 1'b1;
    wait_words(3, 20);
    if (got_q.size() >= 3) begin
      check_eq("t4_w0", got_q[0], 32'h03020100);
      check_eq("t4_w1", got_q[1], 32'h07060504);
      check_eq("t4_w2", got_q[2], 32'hFFFFFFAA);
      check_eq("t4_p2", got_p[2], 1);
    end
`endif

    // 6: random traffic against a byte model
    do_reset(2);
    for (int i = 0; i < 400; i++) rbytes[i] = 8'($urandom_range(255));
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(1) == 0) tick();
          send(rbytes[i]);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(1));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    wait_words(100, 50);
    for (int w = 0; w < 100 && w < got_q.size(); w++) begin
      exp_w = {rbytes[4*w+3], rbytes[4*w+2], rbytes[4*w+1], rbytes[4*w]};
      check_eq($sformatf("t6_w%0d", w), got_q[w], exp_w);
    end
    for (int i = 0; i < 10; i++) tick();
    check_eq("t6_count", got_q.size(), 100);
    check_eq("t6_words", stat_words_out, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
